load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word/double accesses with
// read-modify-write for sub-doubleword stores against an 8-byte memory port.
module load_store_unit #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic [63:0] Mem_Addr,
  output logic [63:0] Write_Data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [63:0] Read_Data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [64:0] LAST_ADDR = 65'(MEM_BYTES - 1);

  state_e      state_q, state_d;
  logic        err_q;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [63:0] mem_addr_q;
  logic [63:0] wr_data_q;

  logic        accept;
  logic        req_err;
  logic        req_dstore;
  logic [64:0] end_addr;

  function automatic logic [63:0] load_ext(input logic [63:0] d, input logic [2:0] f);
    logic [63:0] r;
    case (f)
      3'b000:  r = {{56{d[7]}}, d[7:0]};
      3'b001:  r = {{48{d[15]}}, d[15:0]};
      3'b010:  r = {{32{d[31]}}, d[31:0]};
      3'b100:  r = {56'd0, d[7:0]};
      3'b101:  r = {48'd0, d[15:0]};
      3'b110:  r = {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [1:0] sz);
    logic [63:0] r;
    r = old;
    case (sz)
      2'b00:   r[7:0]  = wd[7:0];
      2'b01:   r[15:0] = wd[15:0];
      2'b10:   r[31:0] = wd[31:0];
      default: r       = wd;
    endcase
    return r;
  endfunction

  // 65-bit end address so an address near 2^64 cannot wrap into range
  assign end_addr   = {1'b0, req_addr} + 65'd7;
  assign req_err    = (req_funct3 == 3'b111) || (req_store && req_funct3[2]) ||
                      (end_addr > LAST_ADDR);
  assign req_dstore = req_store && (req_funct3 == 3'b011);
  assign accept     = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_err)         state_d = RESP;
        else if (req_dstore) state_d = WR;
        else                 state_d = RD;
      end
      RD:      state_d = store_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= req_err;
        if (!req_err) mem_addr_q <= req_addr;
        if (!req_err && req_dstore) wr_data_q <= req_wdata;
      end
      if (state_q == RD && store_q)
        wr_data_q <= store_merge(Read_Data, wdata_q, funct3_q[1:0]);
    end
  end

  // Request payload and captured read data need no reset; outputs are gated by state
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q  <= req_store;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
    if (state_q == RD) rdata_q <= Read_Data;
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_data  = ((state_q == RESP) && !err_q && !store_q) ? load_ext(rdata_q, funct3_q) : '0;
  assign MemRead    = (state_q == RD);
  assign MemWrite   = (state_q == WR);
  assign Mem_Addr   = mem_addr_q;
  assign Write_Data = wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory on the memory port, a byte-level
// reference model, directed boundary cases and randomized traffic.
module tb_load_store_unit;
  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_data;
  logic [63:0] Mem_Addr, Write_Data, Read_Data;
  logic        MemWrite, MemRead;

  logic [7:0] mem     [MB];
  logic [7:0] ref_mem [MB];

  int n_chk = 0;
  int n_err = 0;

  int          last_lat;
  logic [63:0] last_data;
  logic        last_err;
  logic [63:0] last_wd;
  int          last_rd_cnt;
  int          last_wr_cnt;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data)
  );

  // Memory: combinational little-endian read, falling-edge write
  always_comb begin
    Read_Data = '0;
    for (int i = 0; i < 8; i++)
      if (Mem_Addr <= 64'(MB - 1 - i)) Read_Data[i*8 +: 8] = mem[int'(Mem_Addr) + i];
  end

  always @(negedge clk) begin
    if (MemWrite)
      for (int i = 0; i < 8; i++)
        if (Mem_Addr <= 64'(MB - 1 - i)) mem[int'(Mem_Addr) + i] <= Write_Data[i*8 +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = ref_mem[a + i];
    return v;
  endfunction

  task automatic preset(input int a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      mem[a + i]     <= v[i*8 +: 8];
      ref_mem[a + i] =  v[i*8 +: 8];
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input string tag);
    logic        e_err;
    logic [63:0] e_data, e_wd, mask, raw;
    int          e_lat, e_rd, e_wr, nbytes, g, ai;
    logic        overlap, addr_bad, busy_in_resp;
    e_err  = (f3 == 3'd7) || (st && f3[2]) || (a > 64'(MB - 8));
    nbytes = 1 << f3[1:0];
    mask   = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    e_data = '0;
    e_wd   = '0;
    ai     = e_err ? 0 : int'(a);
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!st) begin
      e_lat = 2; e_rd = 1; e_wr = 0;
      raw    = ref_dword(ai) & mask;
      e_data = (f3 < 3'd3 && raw[8*nbytes-1]) ? (raw | ~mask) : raw;
    end else begin
      e_lat = (nbytes == 8) ? 2 : 3;
      e_rd  = (nbytes == 8) ? 0 : 1;
      e_wr  = 1;
      for (int i = 0; i < nbytes; i++) ref_mem[ai + i] = wd[i*8 +: 8];
      e_wd = ref_dword(ai);
    end

    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    last_lat = 99; last_rd_cnt = 0; last_wr_cnt = 0; last_wd = '0;
    overlap = 1'b0; addr_bad = 1'b0; busy_in_resp = 1'b0;
    last_data = '0; last_err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (MemRead && MemWrite) overlap = 1'b1;
      if ((MemRead || MemWrite) && Mem_Addr !== a) addr_bad = 1'b1;
      if (MemRead) last_rd_cnt++;
      if (MemWrite) begin
        last_wr_cnt++;
        last_wd = Write_Data;
      end
      if (resp_valid) begin
        last_lat = k; last_data = resp_data; last_err = resp_err;
        busy_in_resp = MemRead | MemWrite;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(last_lat), 64'(e_lat));
    chk({tag, "_err"}, 64'(last_err), 64'(e_err));
    chk({tag, "_data"}, last_data, e_data);
    chk({tag, "_rdcnt"}, 64'(last_rd_cnt), 64'(e_rd));
    chk({tag, "_wrcnt"}, 64'(last_wr_cnt), 64'(e_wr));
    chk({tag, "_excl"}, 64'(overlap | busy_in_resp), 64'd0);
    chk({tag, "_addr"}, 64'(addr_bad), 64'd0);
    if (st && !e_err) chk({tag, "_wdata"}, last_wd, e_wd);
    @(negedge clk);
  endtask

  initial begin
    int resp_cnt, rd_cnt;
    logic [63:0] v;
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < MB; i++) begin
      v[7:0] = 8'($urandom);
      mem[i] <= v[7:0];
      ref_mem[i] = v[7:0];
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_memrw", {62'd0, MemRead, MemWrite}, 64'd0);
    chk("rst_addr", Mem_Addr, 64'd0);
    chk("rst_wd", Write_Data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    preset(24, 64'h8000_0000_0000_00FF);
    @(negedge clk);
    do_req(1'b0, 3'b000, 64'd24, '0, "lb24");
    chk("lb24_const", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 3'b100, 64'd24, '0, "lbu24");
    chk("lbu24_const", last_data, 64'h0000_0000_0000_00FF);
    do_req(1'b0, 3'b011, 64'd24, '0, "ld24");
    chk("ld24_const", last_data, 64'h8000_0000_0000_00FF);

    preset(8, 64'h1122_3344_5566_7788);
    @(negedge clk);
    do_req(1'b1, 3'b001, 64'd8, 64'h0000_0000_0000_ABCD, "sh8");
    chk("sh8_wd_const", last_wd, 64'h1122_3344_5566_ABCD);
    chk("sh8_lat_const", 64'(last_lat), 64'd3);

    do_req(1'b0, 3'b011, 64'd56, '0, "ld56");
    chk("ld56_err_const", 64'(last_err), 64'd0);
    do_req(1'b0, 3'b011, 64'd57, '0, "ld57");
    chk("ld57_err_const", 64'(last_err), 64'd1);
    chk("ld57_lat_const", 64'(last_lat), 64'd1);
    do_req(1'b0, 3'b111, 64'd0, '0, "f7");
    do_req(1'b1, 3'b100, 64'd0, 64'h55, "sbu_err");
    do_req(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, '0, "ld_wrap");

    do_req(1'b1, 3'b011, 64'd0, 64'hDEAD_BEEF_0123_4567, "sd0");
    do_req(1'b0, 3'b011, 64'd0, '0, "ld0");
    chk("b2b_const", last_data, 64'hDEAD_BEEF_0123_4567);

    // req_valid held high: one acceptance every 3 cycles for a load
    resp_cnt = 0; rd_cnt = 0;
    req_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'd16; req_valid = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
      if (MemRead) rd_cnt++;
    end
    req_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
      if (MemRead) rd_cnt++;
    end
    chk("hold_resps", 64'(resp_cnt), 64'd10);
    chk("hold_reads", 64'(rd_cnt), 64'd10);

    // reset during RD of a load
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'd32;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_inrd", 64'(MemRead), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 64'(req_ready), 64'd1);
    resp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) resp_cnt++;
      @(negedge clk);
    end
    chk("abort_noresp", 64'(resp_cnt), 64'd0);
    do_req(1'b0, 3'b010, 64'd32, '0, "after_abort");

    for (int n = 0; n < 150; n++) begin
      logic [63:0] a, wd;
      logic [2:0]  f3;
      logic        st;
      st = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, MB - 1));
      wd = {$urandom, $urandom};
      do_req(st, f3, a, wd, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
